spi_slave_regfile: RTL and testbench

//  SPI mode-0 slave (responder) with a 32 x 8-bit register file. Counterpart of the SoC's SPI master
//  (spi_0_SCLK/MOSI/SS_n out, MISO in). Used for loopback verification of the master and to emulate
//  MAX3421E-style register peripherals. Protocol: command byte, then data bytes with auto-increment.
//  SPI pins are asynchronous; all logic runs on clk_clk, which must be >= 8x SCLK.

---
 rtl/spi_slave_regfile.sv | 276 +++++++++++++++++++++++++++
 tb/tb_spi_slave_regfile.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// spi_slave_regfile
//
// SPI mode-0 responder (CPOL=0, CPHA=0) in front of a NUM_REGS x 8-bit
// register file. It is the counterpart of the SoC SPI master. It is used for
// master loopback checks and to stand in for MAX3421E-style register
// peripherals.
//
// Transaction format, MSB first on both lines:
//   byte 0 (command) : [7:3] start address, [1] direction (1 = write),
//                      [2] and [0] are don't-care.
//                      MISO returns status_in during this byte.
//   byte 1..n (data) : a write stores MOSI into regs[addr]; a read returns
//                      regs[addr] on MISO. The address advances after every
//                      data byte and wraps from NUM_REGS-1 back to 0.
//
// The SPI pins are asynchronous to clk_clk. They are re-timed by
// SYNC_STAGES flops, and every SPI edge is detected in the clk_clk domain.
// clk_clk must run at least 8x SCLK so that each SCLK phase lasts long
// enough to pass through the synchroniser and the byte pipeline.
//
// Ports
//   clk_clk      in   system clock
//   reset_reset  in   asynchronous, active-high reset
//   spi_sclk     in   SPI clock, idle low
//   spi_mosi     in   master-out data
//   spi_ss_n     in   slave select, active low
//   spi_miso     out  slave-out data
//   spi_miso_oe  out  MISO output enable, high while selected
//   status_in    in   status byte shifted out during the command byte
//   loc_addr     in   local-side register address
//   loc_wdata    in   local-side write data
//   loc_we       in   local-side write enable, one cycle per write
//   loc_rdata    out  regs[loc_addr], registered (1-cycle latency)
//   wr_strobe    out  one-cycle pulse for each completed SPI write byte
//   wr_addr      out  address of the last SPI write (held)
//   wr_data      out  data of the last SPI write (held)
//   rd_strobe    out  one-cycle pulse for each completed SPI read byte
//   busy         out  high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module spi_slave_regfile #(
    parameter  int NUM_REGS    = 32,
    parameter  int SYNC_STAGES = 2,
    localparam int ADDR_W      = $clog2(NUM_REGS)
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_ss_n,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [7:0]        status_in,
    input  logic [ADDR_W-1:0] loc_addr,
    input  logic [7:0]        loc_wdata,
    input  logic              loc_we,
    output logic [7:0]        loc_rdata,
    output logic              wr_strobe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_strobe,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [SYNC_STAGES-1:0] r_sclkSync;
    logic [SYNC_STAGES-1:0] r_mosiSync;
    logic [SYNC_STAGES-1:0] r_ssnSync;
    logic                   r_sclkPrev;
    logic                   r_ssnPrev;

    logic w_sclk;
    logic w_mosi;
    logic w_ssn;
    logic w_sclkRise;
    logic w_sclkFall;
    logic w_ssnRise;
    logic w_ssnFall;

    logic [7:0]        r_rxShift;
    logic [7:0]        r_txShift;
    logic [2:0]        r_bitCnt;
    logic              r_byteDone;
    logic [ADDR_W-1:0] r_addr;
    logic              r_dir;
    logic              r_misoOe;
    logic              r_wrStrobe;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [7:0]        r_wrData;
    logic              r_rdStrobe;
    logic [7:0]        r_locRdata;

    logic [7:0] r_regs [NUM_REGS];

    logic              w_active;
    logic              w_dataByteDone;
    logic              w_spiWe;
    logic [ADDR_W-1:0] w_addrNext;
    logic [7:0]        w_txLoad;

    // Re-time the three SPI inputs. SS_n resets high so that releasing
    // reset does not look like a select edge. SYNC_STAGES must be >= 2.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_sclkSync <= '0;
            r_mosiSync <= '0;
            r_ssnSync  <= '1;
            r_sclkPrev <= 1'b0;
            r_ssnPrev  <= 1'b1;
        end else begin
            r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], spi_sclk};
            r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], spi_mosi};
            r_ssnSync  <= {r_ssnSync[SYNC_STAGES-2:0], spi_ss_n};
            r_sclkPrev <= w_sclk;
            r_ssnPrev  <= w_ssn;
        end
    end

    assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
    assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
    assign w_ssn      = r_ssnSync[SYNC_STAGES-1];
    assign w_sclkRise = w_sclk & ~r_sclkPrev;
    assign w_sclkFall = ~w_sclk & r_sclkPrev;
    assign w_ssnRise  = w_ssn & ~r_ssnPrev;
    assign w_ssnFall  = ~w_ssn & r_ssnPrev;

    // A deselect overrides everything else in the same cycle. This is how a
    // completed byte that is still in the pipeline gets discarded.
    assign w_active       = (r_state != ST_IDLE) && !w_ssnRise;
    assign w_dataByteDone = w_active && r_byteDone && (r_state == ST_DATA);
    assign w_spiWe        = w_dataByteDone && r_dir;
    assign w_addrNext     = (r_addr == ADDR_W'(NUM_REGS - 1)) ? '0 : r_addr + ADDR_W'(1);
    assign w_txLoad       = r_dir ? 8'h00 : r_regs[r_addr];

    // State register.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. A completed command byte moves the FSM to the data
    // phase. Releasing select always returns it to idle.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ssnFall) begin
                    w_nextState = ST_CMD;
                end
            end
            ST_CMD: begin
                if (w_ssnRise) begin
                    w_nextState = ST_IDLE;
                end else if (r_byteDone) begin
                    w_nextState = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_ssnRise) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Shift engine and byte handling.
    //
    // A synced SCLK rise samples MOSI. The eighth rise raises r_byteDone for
    // one cycle, and the byte is acted on in the following cycle. That extra
    // stage puts the strobes SYNC_STAGES+2 clocks after the pin edge.
    //
    // MISO comes straight from bit 7 of the transmit shifter. On a fall at a
    // byte boundary the shifter is reloaded; on any other fall it shifts.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_rxShift  <= '0;
            r_txShift  <= '0;
            r_bitCnt   <= '0;
            r_byteDone <= 1'b0;
            r_addr     <= '0;
            r_dir      <= 1'b0;
            r_misoOe   <= 1'b0;
            r_wrStrobe <= 1'b0;
            r_wrAddr   <= '0;
            r_wrData   <= '0;
            r_rdStrobe <= 1'b0;
        end else begin
            r_byteDone <= 1'b0;
            r_wrStrobe <= 1'b0;
            r_rdStrobe <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (w_ssnFall) begin
                    r_txShift <= status_in;
                    r_bitCnt  <= '0;
                    r_misoOe  <= 1'b1;
                end
            end else if (w_ssnRise) begin
                r_txShift <= '0;
                r_bitCnt  <= '0;
                r_misoOe  <= 1'b0;
            end else begin
                if (w_sclkRise) begin
                    r_rxShift  <= {r_rxShift[6:0], w_mosi};
                    r_bitCnt   <= r_bitCnt + 3'd1;
                    r_byteDone <= (r_bitCnt == 3'd7);
                end
                if (w_sclkFall) begin
                    if (r_bitCnt == 3'd0) begin
                        r_txShift <= w_txLoad;
                    end else begin
                        r_txShift <= {r_txShift[6:0], 1'b0};
                    end
                end
                if (r_byteDone) begin
                    if (r_state == ST_CMD) begin
                        r_addr <= ADDR_W'(r_rxShift[7:3]);
                        r_dir  <= r_rxShift[1];
                    end else begin
                        if (r_dir) begin
                            r_wrStrobe <= 1'b1;
                            r_wrAddr   <= r_addr;
                            r_wrData   <= r_rxShift;
                        end else begin
                            r_rdStrobe <= 1'b1;
                        end
                        r_addr <= w_addrNext;
                    end
                end
            end
        end
    end

    // Register file. The SPI write comes last, so when both ports hit the
    // same address in one cycle the SPI value is kept. The local read port
    // is registered, so a write shows up on the next read.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_locRdata <= '0;
        end else begin
            if (loc_we) begin
                r_regs[loc_addr] <= loc_wdata;
            end
            if (w_spiWe) begin
                r_regs[r_addr] <= r_rxShift;
            end
            r_locRdata <= r_regs[loc_addr];
        end
    end

    assign spi_miso    = r_txShift[7];
    assign spi_miso_oe = r_misoOe;
    assign loc_rdata   = r_locRdata;
    assign wr_strobe   = r_wrStrobe;
    assign wr_addr     = r_wrAddr;
    assign wr_data     = r_wrData;
    assign rd_strobe   = r_rdStrobe;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spi_slave_regfile.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_regfile
//
// Directed bench for spi_slave_regfile. It drives a bit-banged mode-0
// master and compares MISO, the strobe log and the register contents
// against hand-computed values.
//
// All pin changes and output samples happen on clk_clk falling edges,
// which keeps them away from the edges the DUT uses.
// ---------------------------------------------------------------------------
module tb_spi_slave_regfile;

    localparam int HALF = 8;

    logic       clk_clk     = 1'b0;
    logic       reset_reset = 1'b1;
    logic       spi_sclk    = 1'b0;
    logic       spi_mosi    = 1'b0;
    logic       spi_ss_n    = 1'b1;
    logic [7:0] status_in   = 8'h00;
    logic [4:0] loc_addr    = 5'd0;
    logic [7:0] loc_wdata   = 8'h00;
    logic       loc_we      = 1'b0;

    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] loc_rdata;
    logic       wr_strobe;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_strobe;
    logic       busy;

    int vectorsApplied = 0;
    int miscompares    = 0;
    int wrCount        = 0;
    int rdCount        = 0;
    logic [4:0] wrAddrLog [16];
    logic [7:0] wrDataLog [16];

    spi_slave_regfile dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_ss_n    (spi_ss_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .status_in   (status_in),
        .loc_addr    (loc_addr),
        .loc_wdata   (loc_wdata),
        .loc_we      (loc_we),
        .loc_rdata   (loc_rdata),
        .wr_strobe   (wr_strobe),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_strobe   (rd_strobe),
        .busy        (busy)
    );

    // 10-unit system clock. An SCLK half-period is HALF of these clocks.
    always #5 clk_clk = ~clk_clk;

    // Record every strobe. Each strobe is one cycle wide, so each one is
    // seen on exactly one falling edge.
    always @(negedge clk_clk) begin
        if (wr_strobe) begin
            if (wrCount < 16) begin
                wrAddrLog[wrCount] = wr_addr;
                wrDataLog[wrCount] = wr_data;
            end
            wrCount++;
        end
        if (rd_strobe) begin
            rdCount++;
        end
    end

    // Safety net in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Single comparison point: every check is counted here, and each
    // mismatch is reported here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Shift nBits of txByte out MSB first, and capture MISO just before each
    // rising edge. With collide set, a local write is pulsed on the same
    // clock as the SPI register write for the eighth bit. That clock is four
    // clocks after the final SCLK pin rise.
    task automatic applyStimulus(input logic [7:0] txByte, input int nBits,
                                 input bit collide, output logic [7:0] rxByte);
        rxByte = 8'h00;
        for (int i = 7; i >= 8 - nBits; i--) begin
            spi_mosi = txByte[i];
            repeat (HALF) @(negedge clk_clk);
            rxByte[i] = spi_miso;
            spi_sclk = 1'b1;
            for (int k = 0; k < HALF; k++) begin
                @(negedge clk_clk);
                if (collide && i == 0) begin
                    if (k == 2) begin
                        loc_we = 1'b1;
                    end else if (k == 3) begin
                        loc_we = 1'b0;
                    end
                end
            end
            spi_sclk = 1'b0;
        end
    endtask

    task automatic selectSlave();
        @(negedge clk_clk);
        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clk_clk);
    endtask

    task automatic deselectSlave();
        repeat (HALF) @(negedge clk_clk);
        spi_ss_n = 1'b1;
        repeat (2 * HALF) @(negedge clk_clk);
    endtask

    task automatic readLocal(input logic [4:0] addr, output logic [7:0] data);
        @(negedge clk_clk);
        loc_addr = addr;
        @(negedge clk_clk);
        data = loc_rdata;
    endtask

    task automatic writeLocal(input logic [4:0] addr, input logic [7:0] data);
        @(negedge clk_clk);
        loc_addr  = addr;
        loc_wdata = data;
        loc_we    = 1'b1;
        @(negedge clk_clk);
        loc_we = 1'b0;
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, " miso"}, spi_miso, 0);
        checkOutput({tag, " oe"}, spi_miso_oe, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " wr_strobe"}, wr_strobe, 0);
        checkOutput({tag, " rd_strobe"}, rd_strobe, 0);
    endtask

    // Main sequence. T2-T6 are run first so that the register file holds
    // nonzero data by the time the mid-transaction reset test clears it.
    initial begin
        logic [7:0] rx;
        logic [7:0] rd;
        int         wrBase;
        int         rdBase;

        // Power-on reset values.
        repeat (4) @(negedge clk_clk);
        checkIdleOutputs("reset0");
        checkOutput("reset0 wr_addr", wr_addr, 0);
        checkOutput("reset0 wr_data", wr_data, 0);
        checkOutput("reset0 loc_rdata", loc_rdata, 0);
        reset_reset = 1'b0;
        repeat (4) @(negedge clk_clk);

        // T2: write 0x3C and 0x7E starting at address 1.
        $display("[TB] T2 write burst");
        status_in = 8'hA5;
        wrBase = wrCount;
        rdBase = rdCount;
        selectSlave();
        checkOutput("T2 oe while selected", spi_miso_oe, 1);
        checkOutput("T2 busy while selected", busy, 1);
        applyStimulus(8'h0A, 8, 1'b0, rx);
        checkOutput("T2 miso status", rx, 8'hA5);
        applyStimulus(8'h3C, 8, 1'b0, rx);
        checkOutput("T2 miso data0", rx, 8'h00);
        applyStimulus(8'h7E, 8, 1'b0, rx);
        checkOutput("T2 miso data1", rx, 8'h00);
        deselectSlave();
        checkOutput("T2 wr count", wrCount - wrBase, 2);
        checkOutput("T2 rd count", rdCount - rdBase, 0);
        checkOutput("T2 wr0 addr", wrAddrLog[wrBase], 1);
        checkOutput("T2 wr0 data", wrDataLog[wrBase], 8'h3C);
        checkOutput("T2 wr1 addr", wrAddrLog[wrBase+1], 2);
        checkOutput("T2 wr1 data", wrDataLog[wrBase+1], 8'h7E);
        checkOutput("T2 wr_addr held", wr_addr, 2);
        checkOutput("T2 wr_data held", wr_data, 8'h7E);
        checkIdleOutputs("T2 after deselect");
        readLocal(5'd1, rd);
        checkOutput("T2 regs[1]", rd, 8'h3C);
        readLocal(5'd2, rd);
        checkOutput("T2 regs[2]", rd, 8'h7E);

        // T3: read the same two registers back over SPI.
        $display("[TB] T3 read burst");
        wrBase = wrCount;
        rdBase = rdCount;
        selectSlave();
        applyStimulus(8'h08, 8, 1'b0, rx);
        checkOutput("T3 miso status", rx, 8'hA5);
        applyStimulus(8'h00, 8, 1'b0, rx);
        checkOutput("T3 miso regs[1]", rx, 8'h3C);
        applyStimulus(8'h00, 8, 1'b0, rx);
        checkOutput("T3 miso regs[2]", rx, 8'h7E);
        deselectSlave();
        checkOutput("T3 rd count", rdCount - rdBase, 2);
        checkOutput("T3 wr count", wrCount - wrBase, 0);

        // T4: the address wraps from 31 back to 0.
        $display("[TB] T4 address wrap");
        status_in = 8'h3C;
        wrBase = wrCount;
        selectSlave();
        applyStimulus(8'hFA, 8, 1'b0, rx);
        checkOutput("T4 miso status", rx, 8'h3C);
        applyStimulus(8'h11, 8, 1'b0, rx);
        applyStimulus(8'h22, 8, 1'b0, rx);
        deselectSlave();
        checkOutput("T4 wr count", wrCount - wrBase, 2);
        checkOutput("T4 wr0 addr", wrAddrLog[wrBase], 31);
        checkOutput("T4 wr0 data", wrDataLog[wrBase], 8'h11);
        checkOutput("T4 wr1 addr", wrAddrLog[wrBase+1], 0);
        checkOutput("T4 wr1 data", wrDataLog[wrBase+1], 8'h22);
        readLocal(5'd31, rd);
        checkOutput("T4 regs[31]", rd, 8'h11);
        readLocal(5'd0, rd);
        checkOutput("T4 regs[0]", rd, 8'h22);

        // T5: a partial data byte is discarded when select is released.
        $display("[TB] T5 abort");
        writeLocal(5'd3, 8'h44);
        wrBase = wrCount;
        selectSlave();
        applyStimulus(8'h1A, 8, 1'b0, rx);
        applyStimulus(8'hFF, 5, 1'b0, rx);
        deselectSlave();
        checkOutput("T5 wr count", wrCount - wrBase, 0);
        checkIdleOutputs("T5 after abort");
        readLocal(5'd3, rd);
        checkOutput("T5 regs[3]", rd, 8'h44);

        // T6: the SPI write wins a same-address collision; writes to
        // different addresses both land.
        $display("[TB] T6 collision");
        wrBase = wrCount;
        selectSlave();
        applyStimulus(8'h1A, 8, 1'b0, rx);
        loc_addr  = 5'd3;
        loc_wdata = 8'h55;
        applyStimulus(8'h99, 8, 1'b1, rx);
        checkOutput("T6 miso data0", rx, 8'h00);
        loc_addr  = 5'd5;
        loc_wdata = 8'h77;
        applyStimulus(8'h66, 8, 1'b1, rx);
        deselectSlave();
        checkOutput("T6 wr count", wrCount - wrBase, 2);
        checkOutput("T6 wr0 addr", wrAddrLog[wrBase], 3);
        checkOutput("T6 wr0 data", wrDataLog[wrBase], 8'h99);
        checkOutput("T6 wr1 addr", wrAddrLog[wrBase+1], 4);
        checkOutput("T6 wr1 data", wrDataLog[wrBase+1], 8'h66);
        readLocal(5'd3, rd);
        checkOutput("T6 regs[3] same-addr", rd, 8'h99);
        readLocal(5'd4, rd);
        checkOutput("T6 regs[4] spi", rd, 8'h66);
        readLocal(5'd5, rd);
        checkOutput("T6 regs[5] local", rd, 8'h77);

        // T1: reset in the middle of a data byte clears everything at once
        // and issues no strobe.
        $display("[TB] T1 mid-transaction reset");
        wrBase = wrCount;
        rdBase = rdCount;
        selectSlave();
        applyStimulus(8'h0A, 8, 1'b0, rx);
        applyStimulus(8'hFF, 4, 1'b0, rx);
        reset_reset = 1'b1;
        @(negedge clk_clk);
        checkIdleOutputs("T1 in reset");
        checkOutput("T1 wr_addr", wr_addr, 0);
        checkOutput("T1 wr_data", wr_data, 0);
        checkOutput("T1 loc_rdata", loc_rdata, 0);
        spi_ss_n = 1'b1;
        repeat (4) @(negedge clk_clk);
        reset_reset = 1'b0;
        repeat (4) @(negedge clk_clk);
        checkIdleOutputs("T1 after reset");
        checkOutput("T1 wr count", wrCount - wrBase, 0);
        checkOutput("T1 rd count", rdCount - rdBase, 0);
        for (int a = 0; a < 32; a++) begin
            readLocal(5'(a), rd);
            checkOutput($sformatf("T1 regs[%0d]", a), rd, 8'h00);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
